// File: rtl/aes_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer_if
//   Handshake bundle between the AES round sequencer and the datapath /
//   key-schedule blocks it controls.
//
//   start      : request to encrypt the block on the state input (to sequencer)
//   key_valid  : round key for the current round is available   (to sequencer)
//   op_ack     : datapath finished the operation being issued    (to sequencer)
//   load_state : one-cycle pulse, datapath captures plaintext    (from sequencer)
//   op_valid   : an operation is being issued                    (from sequencer)
//   op_sel     : 0=NONE 1=SUB 2=SHIFT 3=MIX 4=ADDKEY             (from sequencer)
//   round      : current round index 0..NUM_ROUNDS               (from sequencer)
//   busy       : high from LOAD through the final ADDKEY         (from sequencer)
//   done       : one-cycle pulse, ciphertext is in the state reg (from sequencer)
//
//   master : the sequencer side
//   slave  : the datapath / key-schedule side
// ---------------------------------------------------------------------------
interface aes_round_sequencer_if;
   logic       start;
   logic       key_valid;
   logic       op_ack;
   logic       load_state;
   logic       op_valid;
   logic [2:0] op_sel;
   logic [3:0] round;
   logic       busy;
   logic       done;

   modport master (
      input  start,
      input  key_valid,
      input  op_ack,
      output load_state,
      output op_valid,
      output op_sel,
      output round,
      output busy,
      output done
   );

   modport slave (
      output start,
      output key_valid,
      output op_ack,
      input  load_state,
      input  op_valid,
      input  op_sel,
      input  round,
      input  busy,
      input  done
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//   Control FSM for the AES-128 encryption datapath. After a start request it
//   loads the plaintext, issues the initial AddRoundKey, then for each round
//   issues SubBytes, ShiftRows, MixColumns and AddRoundKey one at a time over
//   a valid/ack handshake. The final round skips MixColumns. The round index
//   is exported so the key schedule can present the matching round key.
//
// Parameters
//   NUM_ROUNDS : cipher rounds after the initial AddRoundKey (1..15)
//
// Ports
//   clk   : system clock, all logic on posedge
//   reset : synchronous, active-high; returns the FSM to IDLE
//   bus   : aes_round_sequencer_if.master handshake bundle
//           (start, key_valid, op_ack in; load_state, op_valid, op_sel,
//            round, busy, done out)
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   aes_round_sequencer_if.master   bus
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SUB,
      S_SHIFT,
      S_MIX,
      S_ADDKEY,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      OP_NONE   = 3'd0,
      OP_SUB    = 3'd1,
      OP_SHIFT  = 3'd2,
      OP_MIX    = 3'd3,
      OP_ADDKEY = 3'd4
   } op_e;

   state_e     state_q,      state_d;
   logic [3:0] round_q,      round_d;
   logic       load_state_q, load_state_d;
   logic       issue_q,      issue_d;      // SUB/SHIFT/MIX: valid unconditionally
   logic       addkey_q,     addkey_d;     // ADDKEY: valid follows key_valid
   op_e        op_sel_q,     op_sel_d;
   logic       busy_q,       busy_d;
   logic       done_q,       done_d;

   logic       op_valid;
   logic       accept;

   // The only input-to-output path: in ADDKEY the issue is gated by key_valid.
   assign op_valid = issue_q | (addkey_q & bus.key_valid);
   assign accept   = op_valid & bus.op_ack;

   // Next state, then every registered output decoded from the next state so
   // the outputs line up with the state they describe.
   always_comb begin
      state_d = state_q;
      round_d = round_q;

      unique case (state_q)
         S_IDLE: begin
            round_d = '0;
            if (bus.start) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            round_d = '0;
            state_d = S_ADDKEY;
         end
         S_SUB: begin
            if (accept) begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (accept) begin
               // Last round has no MixColumns.
               state_d = (round_q < LAST_ROUND) ? S_MIX : S_ADDKEY;
            end
         end
         S_MIX: begin
            if (accept) begin
               state_d = S_ADDKEY;
            end
         end
         S_ADDKEY: begin
            if (accept) begin
               if (round_q < LAST_ROUND) begin
                  round_d = round_q + 4'd1;
                  state_d = S_SUB;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            round_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            round_d = '0;
            state_d = S_IDLE;
         end
      endcase

      load_state_d = 1'b0;
      issue_d      = 1'b0;
      addkey_d     = 1'b0;
      op_sel_d     = OP_NONE;
      busy_d       = 1'b0;
      done_d       = 1'b0;

      unique case (state_d)
         S_LOAD: begin
            load_state_d = 1'b1;
            busy_d       = 1'b1;
         end
         S_SUB: begin
            issue_d  = 1'b1;
            op_sel_d = OP_SUB;
            busy_d   = 1'b1;
         end
         S_SHIFT: begin
            issue_d  = 1'b1;
            op_sel_d = OP_SHIFT;
            busy_d   = 1'b1;
         end
         S_MIX: begin
            issue_d  = 1'b1;
            op_sel_d = OP_MIX;
            busy_d   = 1'b1;
         end
         S_ADDKEY: begin
            addkey_d = 1'b1;
            op_sel_d = OP_ADDKEY;
            busy_d   = 1'b1;
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         round_q      <= '0;
         load_state_q <= 1'b0;
         issue_q      <= 1'b0;
         addkey_q     <= 1'b0;
         op_sel_q     <= OP_NONE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         round_q      <= round_d;
         load_state_q <= load_state_d;
         issue_q      <= issue_d;
         addkey_q     <= addkey_d;
         op_sel_q     <= op_sel_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.load_state = load_state_q;
   assign bus.op_valid   = op_valid;
   assign bus.op_sel     = op_sel_q;
   assign bus.round      = round_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM that sequences the AES-128 encryption datapath: SubBytes, ShiftRows, MixColumns and AddRoundKey, each run one at a time per round. It sits above the state-transform units and issues one operation at a time over a valid/ack handshake. It tracks the round index, so the key-schedule block can present the matching round key. The final round skips MixColumns.

## Interface
- NUM_ROUNDS, 10, number of cipher rounds after the initial AddRoundKey. Legal range is 1..15.

- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high; forces IDLE
- start  input  1  request to encrypt the block on the state input; sampled only in IDLE
- key_valid  input  1  round key for the current `round` is available
- op_ack  input  1  datapath has completed the operation currently issued
- load_state  output  1  one-cycle pulse: datapath captures the plaintext into the state register
- op_valid  output  1  an operation is being issued
- op_sel  output  3  0=NONE, 1=SUB, 2=SHIFT, 3=MIX, 4=ADDKEY
- round  output  4  current round index, 0..NUM_ROUNDS
- busy  output  1  high from LOAD through the final ADDKEY
- done  output  1  one-cycle pulse: ciphertext is in the state register

## Operation
- States: IDLE, LOAD, SUB, SHIFT, MIX, ADDKEY, DONE.
- IDLE:
  - all outputs 0; round=0.
  - start=1 → LOAD.
- LOAD:
  - load_state=1, busy=1, op_valid=0.
  - Unconditionally → ADDKEY with round=0.
- Op states (SUB, SHIFT, MIX, ADDKEY):
  - op_sel = state code, busy=1.
  - op_valid=1 in SUB, SHIFT and MIX.
  - In ADDKEY, op_valid = key_valid.
- Advance only on a posedge where op_valid=1 and op_ack=1. Otherwise hold the state, op_sel and round unchanged.
- Transitions on an accepted op:
  - SUB → SHIFT.
  - SHIFT → MIX if round<NUM_ROUNDS, else → ADDKEY.
  - MIX → ADDKEY.
  - ADDKEY → round+1 and SUB if round<NUM_ROUNDS; → DONE if round==NUM_ROUNDS.
- round increments only on ADDKEY acceptance. It is held through SUB, SHIFT and MIX of the same round.
- DONE:
  - done=1, busy=0, op_valid=0, round held at NUM_ROUNDS.
  - Unconditionally → IDLE, where round clears to 0.
- Ignored inputs:
  - start outside IDLE, including during DONE. No queuing.
  - op_ack while op_valid=0, including ADDKEY with key_valid=0.
- round is 4 bits; no wrap, since NUM_ROUNDS≤15.

## Timing
- Reset:
  - The state is IDLE on the cycle after the posedge where reset=1.
  - Reset has priority over every other input, including mid-operation. No done pulse is produced and no partial state is kept.
  - Reset values: load_state=0, op_valid=0, op_sel=0, round=0, busy=0, done=0.
- Outputs are registered/Moore from state; no combinational path from inputs to outputs, except op_valid←key_valid in ADDKEY.
- Latency with op_ack and key_valid tied high, start sampled at edge E0:
  - cycle 1: LOAD
  - cycle 2: ADDKEY round 0
  - cycles 3–38: rounds 1–9, 4 cycles each
  - cycles 39–41: round 10 SUB, SHIFT, ADDKEY
  - cycle 42: DONE
  - cycle 43: IDLE
- General latency: 2 + 4·(NUM_ROUNDS−1) + 3 + 1 cycles to done, plus stall cycles.
- Minimum op occupancy is 1 cycle. An ack held high acknowledges consecutive ops back-to-back.
- Earliest next start is sampled in IDLE at cycle 43, giving LOAD at cycle 44.

## Test plan
- Nominal run:
  - Stimulus: NUM_ROUNDS=10, op_ack=key_valid=1, start pulse at E0.
  - Required: op_sel trace 4, then (1,2,3,4)×9, then 1,2,4. done=1 exactly at cycle 42. round reaches 10. busy spans cycles 1–41.
- Ack stall:
  - Stimulus: hold op_ack=0 for 3 cycles during round 5 SHIFT.
  - Required: op_sel=2 and round=5 held for 4 cycles total. done is delayed to cycle 45.
- Key stall:
  - Stimulus: key_valid=0 for 2 cycles at round 0 ADDKEY, with op_ack=1 throughout.
  - Required: op_valid=0 and no advance for those 2 cycles. done at cycle 44.
- Start while busy:
  - Stimulus: start=1 during cycles 10 and 42.
  - Required: no effect. A single done at cycle 42, then IDLE with busy=0.
- Reset mid-run:
  - Stimulus: reset=1 at cycle 20 (round 5).
  - Required: next cycle all outputs 0 and round=0, no done pulse. A fresh start then completes in 42 cycles.
- Minimal config:
  - Stimulus: NUM_ROUNDS=1, op_ack=key_valid=1.
  - Required: op_sel trace 4,1,2,4 with rounds 0,1,1,1. done at cycle 6.
